// File: rtl/rr_arb16_pkg.sv
// Shared constants and types for the 16-channel round-robin arbiter family.
// Other arbiters import HOLD_MAX_DEFAULT so that all hold timeouts agree.
package rr_arb16_pkg;

  localparam int NCH              = 16;
  localparam int IDX_W            = 4;
  localparam int HOLD_MAX_DEFAULT = 255;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Advances a channel index; the 4-bit width makes 15 wrap to 0.
  function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx);
    return idx + 4'd1;
  endfunction

endpackage

// File: rtl/rr_arb16_if.sv
// Request/grant bundle between the channels and the arbiter.
// The arbiter takes the slave view; the channel side takes the master view.
interface rr_arb16_if;
  import rr_arb16_pkg::*;

  logic [NCH-1:0]   req;
  logic             done;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic             timeout;

  modport master (
    output req,
    output done,
    input  gnt_valid,
    input  gnt_idx,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt_valid,
    output gnt_idx,
    output timeout
  );

endinterface

// File: rtl/rr_pick16.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Rotates the request vector so ptr lands at bit 0, finds the lowest set bit, then un-rotates.
module rr_pick16
  import rr_arb16_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [2*NCH-1:0] dbl_s;
  logic [NCH-1:0]   rot_s;
  logic [IDX_W-1:0] off_s;

  // Rotate right by ptr using a doubled copy so the wrap-around bits come for free.
  always_comb begin
    dbl_s = {req, req} >> ptr;
    rot_s = dbl_s[NCH-1:0];
  end

  // Find-first-set on the rotated vector; scanning downward lets the lowest set bit win.
  always_comb begin
    off_s = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = i[IDX_W-1:0];
      end else begin
        off_s = off_s;
      end
    end
  end

  // Undo the rotation; the 4-bit sum wraps modulo 16.
  always_comb begin
    any = |req;
    idx = off_s + ptr;
  end

endmodule

// File: rtl/rr_arb16.sv
// 16-requester round-robin arbiter with bounded hold and a mandatory idle gap
// between grants, so the downstream 4-to-16 decoder never switches channels in one cycle.
module rr_arb16
  import rr_arb16_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT,
  parameter int CNT_W    = 8
)(
  input  logic        clk,
  input  logic        rst,
  rr_arb16_if.slave   bus
);

  localparam logic [0:0]       S_IDLE    = IDLE;
  localparam logic [0:0]       S_GRANT   = GRANT;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [0:0]       state_r,     state_nxt_s;
  logic [IDX_W-1:0] ptr_r,       ptr_nxt_s;
  logic [CNT_W-1:0] cnt_r,       cnt_nxt_s;
  logic             gnt_valid_r, gnt_valid_nxt_s;
  logic [IDX_W-1:0] gnt_idx_r,   gnt_idx_nxt_s;
  logic             timeout_r,   timeout_nxt_s;

  logic             pick_any_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             release_s;
  logic             hold_hit_s;

  rr_pick16 u_pick (
    .req (bus.req),
    .ptr (ptr_r),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  // Release and timeout conditions for the current grant; done outranks the timeout.
  always_comb begin
    release_s  = bus.done || !bus.req[gnt_idx_r];
    hold_hit_s = (HOLD_MAX != 0) && (cnt_r == HOLD_LAST);
  end

  // Next-state logic: IDLE picks, GRANT holds until release or hold limit.
  always_comb begin
    state_nxt_s     = state_r;
    ptr_nxt_s       = ptr_r;
    cnt_nxt_s       = cnt_r;
    gnt_valid_nxt_s = gnt_valid_r;
    gnt_idx_nxt_s   = gnt_idx_r;
    timeout_nxt_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (pick_any_s) begin
          state_nxt_s     = S_GRANT;
          gnt_valid_nxt_s = 1'b1;
          gnt_idx_nxt_s   = pick_idx_s;
          cnt_nxt_s       = '0;
        end else begin
          gnt_valid_nxt_s = 1'b0;
        end
      end
      S_GRANT: begin
        if (release_s) begin
          state_nxt_s     = S_IDLE;
          gnt_valid_nxt_s = 1'b0;
          ptr_nxt_s       = idx_next(gnt_idx_r);
        end else if (hold_hit_s) begin
          state_nxt_s     = S_IDLE;
          gnt_valid_nxt_s = 1'b0;
          ptr_nxt_s       = idx_next(gnt_idx_r);
          timeout_nxt_s   = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s     = S_IDLE;
        gnt_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any active grant at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      ptr_r       <= '0;
      cnt_r       <= '0;
      gnt_valid_r <= 1'b0;
      gnt_idx_r   <= '0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ptr_r       <= ptr_nxt_s;
      cnt_r       <= cnt_nxt_s;
      gnt_valid_r <= gnt_valid_nxt_s;
      gnt_idx_r   <= gnt_idx_nxt_s;
      timeout_r   <= timeout_nxt_s;
    end
  end

  assign bus.gnt_valid = gnt_valid_r;
  assign bus.gnt_idx   = gnt_idx_r;
  assign bus.timeout   = timeout_r;

endmodule

// File: tb/tb_rr_arb16.sv
// Bench for rr_arb16: directed scenarios with literal expectations plus randomized
// traffic, all compared every cycle against a channel-level round-robin model.
module tb_rr_arb16;

  localparam int HOLD = 4;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: who holds the grant, for how many cycles, and where the search starts.
  bit m_valid = 1'b0;
  int m_idx   = 0;
  bit m_to    = 1'b0;
  int m_ptr   = 0;
  int m_held  = 0;

  rr_arb16_if bus ();

  assign bus.req  = req;
  assign bus.done = done;

  rr_arb16 #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sees at that edge.
  task automatic model_step();
    bit found;
    if (rst) begin
      m_valid = 1'b0; m_idx = 0; m_to = 1'b0; m_ptr = 0; m_held = 0;
    end else if (!m_valid) begin
      m_to  = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 16; k++) begin
        if (!found && req[(m_ptr + k) % 16]) begin
          found  = 1'b1;
          m_idx  = (m_ptr + k) % 16;
        end
      end
      if (found) begin
        m_valid = 1'b1;
        m_held  = 1;
      end
    end else if (done || !req[m_idx]) begin
      m_valid = 1'b0; m_to = 1'b0; m_ptr = (m_idx + 1) % 16;
    end else if (HOLD != 0 && m_held == HOLD) begin
      m_valid = 1'b0; m_to = 1'b1; m_ptr = (m_idx + 1) % 16;
    end else begin
      m_held++;
      m_to = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model_gnt_valid", {15'd0, bus.gnt_valid}, {15'd0, m_valid});
    check("model_gnt_idx",   {12'd0, bus.gnt_idx},   16'(m_idx));
    check("model_timeout",   {15'd0, bus.timeout},   {15'd0, m_to});
  endtask

  task automatic wait_grant(input int budget);
    for (int i = 0; i < budget && bus.gnt_valid !== 1'b1; i++) tick();
    check("wait_grant", {15'd0, bus.gnt_valid}, 16'd1);
  endtask

  task automatic lit(input string name, input logic [15:0] act, input int exp);
    check(name, act, 16'(exp));
  endtask

  initial begin
    logic [3:0] fair_exp [4];
    fair_exp = '{4'd0, 4'd15, 4'd0, 4'd15};

    // Reset with every channel requesting.
    rst = 1'b1; req = 16'hFFFF; done = 1'b0;
    repeat (2) begin
      tick();
      lit("rst_valid", {15'd0, bus.gnt_valid}, 0);
      lit("rst_idx",   {12'd0, bus.gnt_idx},   0);
      lit("rst_to",    {15'd0, bus.timeout},   0);
    end
    rst = 1'b0;
    tick();
    lit("first_valid", {15'd0, bus.gnt_valid}, 1);
    lit("first_idx",   {12'd0, bus.gnt_idx},   0);

    // Single requester on channel 5; done lands on the last permitted hold cycle.
    req = 16'h0020; done = 1'b1;
    tick();
    lit("done_release", {15'd0, bus.gnt_valid}, 0);
    done = 1'b0;
    tick();
    lit("single_valid", {15'd0, bus.gnt_valid}, 1);
    lit("single_idx",   {12'd0, bus.gnt_idx},   5);
    repeat (3) tick();
    lit("single_hold", {15'd0, bus.gnt_valid}, 1);
    done = 1'b1;
    tick();
    lit("single_drop", {15'd0, bus.gnt_valid}, 0);
    lit("single_no_to", {15'd0, bus.timeout},  0);
    done = 1'b0;
    tick();
    lit("single_regrant", {12'd0, bus.gnt_idx}, 5);

    // Fairness between channels 0 and 15 starting from a fresh pointer.
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 16'h8001;
    for (int k = 0; k < 4; k++) begin
      wait_grant(4);
      lit("fair_idx", {12'd0, bus.gnt_idx}, int'(fair_exp[k]));
      done = 1'b1;
      tick();
      done = 1'b0;
    end

    // Grant to 14 then release: pointer 15 must wrap so channel 0 wins.
    req = 16'h4000;
    wait_grant(4);
    lit("wrap_14", {12'd0, bus.gnt_idx}, 14);
    req = 16'h4001; done = 1'b1;
    tick();
    done = 1'b0;
    wait_grant(4);
    lit("wrap_0", {12'd0, bus.gnt_idx}, 0);

    // Hold timeout on channel 2.
    req = 16'h0004;
    tick();
    wait_grant(4);
    lit("to_idx", {12'd0, bus.gnt_idx}, 2);
    repeat (3) begin
      tick();
      lit("to_hold", {15'd0, bus.gnt_valid}, 1);
      lit("to_quiet", {15'd0, bus.timeout},  0);
    end
    tick();
    lit("to_drop",  {15'd0, bus.gnt_valid}, 0);
    lit("to_pulse", {15'd0, bus.timeout},   1);
    tick();
    lit("to_regrant", {12'd0, bus.gnt_idx},  2);
    lit("to_cleared", {15'd0, bus.timeout},  0);

    // Requester withdraw, then reset in the middle of a grant.
    req = 16'h0080;
    tick();
    lit("wd_drop2", {15'd0, bus.gnt_valid}, 0);
    wait_grant(4);
    lit("wd_idx7", {12'd0, bus.gnt_idx}, 7);
    req = 16'h0000;
    tick();
    lit("wd_drop7", {15'd0, bus.gnt_valid}, 0);
    lit("wd_no_to", {15'd0, bus.timeout},   0);
    req = 16'h0080;
    wait_grant(4);
    rst = 1'b1;
    tick();
    lit("midrst_valid", {15'd0, bus.gnt_valid}, 0);
    lit("midrst_idx",   {12'd0, bus.gnt_idx},   0);
    rst = 1'b0; req = 16'hFFFF;
    tick();
    lit("midrst_ptr0", {12'd0, bus.gnt_idx}, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       req = 16'($urandom) & 16'($urandom) & 16'($urandom);
          1:       req = 16'($urandom);
          default: req = 16'(1 << $urandom_range(0, 15));
        endcase
      end
      done = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
